// File: rtl/ped_request_ctrl_pkg.sv
// Shared types and constants for the pedestrian request conditioner.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2,
    LOCKOUT = 2'd3
  } ped_state_t;

  localparam int SYNC_DEPTH = 2;
  localparam int DB_CNT_W   = 4;

endpackage

// File: rtl/ped_request_ctrl_if.sv
// Button/controller-side signal bundle; req_count exists only with PED_REQ_CNT_EN.
interface ped_request_ctrl_if
`ifdef PED_REQ_CNT_EN
  #(parameter int CNT_W = 8)
`endif
  ;

  logic btn_raw;
  logic walk;
  logic ped;
  logic btn_clean;
  logic lockout;
`ifdef PED_REQ_CNT_EN
  logic [CNT_W-1:0] req_count;

  modport master (output btn_raw, walk, input ped, btn_clean, lockout, req_count);
  modport slave  (input btn_raw, walk, output ped, btn_clean, lockout, req_count);
`else
  modport master (output btn_raw, walk, input ped, btn_clean, lockout);
  modport slave  (input btn_raw, walk, output ped, btn_clean, lockout);
`endif

endinterface

// File: rtl/ped_request_ctrl_debounce.sv
// Two-flop synchroniser plus stability counter; btn_clean follows btn_sync
// only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_clean
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [DB_CNT_W-1:0]   cnt;
  logic                  btn_sync;

  assign btn_sync = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt       <= '0;
      btn_clean <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], btn_raw};
      // Any cycle of agreement restarts the stability window.
      if (btn_sync == btn_clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_clean <= btn_sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ped_request_ctrl.sv
// Conditions the push-button into a latched ped request with post-walk lockout
// and press queueing; PED_REQ_CNT_EN adds a saturating accepted-request counter.
module ped_request_ctrl
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
`ifdef PED_REQ_CNT_EN
  ,
  parameter int CNT_W           = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  ped_request_ctrl_if.slave bus
);

  localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

  ped_state_t state, state_nxt;
  logic       clean_q;
  logic       walk_q;
  logic       press;
  logic       walk_fall;
  logic       queued, queued_nxt;
  logic       ped_q;
  logic [7:0] lock_cnt;
  logic       lock_last;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (bus.btn_raw),
    .btn_clean(bus.btn_clean)
  );

  assign press     = bus.btn_clean & ~clean_q;
  assign walk_fall = walk_q & ~bus.walk;
  assign lock_last = (lock_cnt == 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      queued   <= 1'b0;
      ped_q    <= 1'b0;
      clean_q  <= 1'b0;
      walk_q   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state   <= state_nxt;
      queued  <= queued_nxt;
      ped_q   <= (state_nxt == PENDING);
      clean_q <= bus.btn_clean;
      walk_q  <= bus.walk;
      if (state == SERVING && state_nxt == LOCKOUT) begin
        lock_cnt <= LOCK_LOAD;
      end else if (state == LOCKOUT) begin
        lock_cnt <= lock_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    queued_nxt = queued;
    case (state)
      IDLE: begin
        if (press) state_nxt = PENDING;
      end
      PENDING: begin
        if (bus.walk) state_nxt = SERVING;
      end
      SERVING: begin
        queued_nxt = queued | press;
        if (walk_fall) begin
          // A zero-length lockout resolves the queue immediately.
          if (LOCKOUT_CYCLES == 0) begin
            state_nxt  = (queued | press) ? PENDING : IDLE;
            queued_nxt = 1'b0;
          end else begin
            state_nxt = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        queued_nxt = queued | press;
        if (lock_last) begin
          state_nxt  = (queued | press) ? PENDING : IDLE;
          queued_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        queued_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.ped     = ped_q;
    bus.lockout = (state == LOCKOUT);
  end

`ifdef PED_REQ_CNT_EN
  logic [CNT_W-1:0] req_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt <= '0;
    end else if (state != PENDING && state_nxt == PENDING && !(&req_cnt)) begin
      req_cnt <= req_cnt + CNT_W'(1);
    end
  end

  assign bus.req_count = req_cnt;
`endif

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Table-driven, hand-sequenced and randomized checks of ped_request_ctrl against a history-based model.
module tb_ped_request_ctrl;

  localparam int D    = 4;
  localparam int L    = 8;
  localparam int CMAX = 3;

  localparam int M_IDLE = 0;
  localparam int M_PEND = 1;
  localparam int M_SERV = 2;
  localparam int M_LOCK = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef PED_REQ_CNT_EN
  ped_request_ctrl_if #(.CNT_W(2)) bus ();
  ped_request_ctrl #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`else
  ped_request_ctrl_if bus ();
  ped_request_ctrl #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model: raw-input history decides debouncing; FSM kept as plain integers.
  bit m_raw_h [0:19];
  bit m_clean, m_clean_q, m_walk_prev, m_q;
  int m_mode, m_rem, m_cnt;

  typedef struct {
    bit raw;
    bit walk;
    bit e_ped;
    bit e_lock;
    bit e_clean;
  } vec_t;
  vec_t tbl [32];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 20; i++) m_raw_h[i] = 1'b0;
    m_clean = 0; m_clean_q = 0; m_walk_prev = 0; m_q = 0;
    m_mode = M_IDLE; m_rem = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit raw, input bit walk);
    bit press, fall, flip, qe;
    int prev_mode;
    for (int i = 19; i > 0; i--) m_raw_h[i] = m_raw_h[i-1];
    m_raw_h[0] = raw;
    // The synced sample seen at this edge is raw from two edges ago.
    flip = 1'b1;
    for (int k = 2; k <= D + 1; k++) if (m_raw_h[k] == m_clean) flip = 1'b0;
    press = m_clean & ~m_clean_q;
    fall  = m_walk_prev & ~walk;
    m_clean_q = m_clean;
    if (flip) m_clean = ~m_clean;
    m_walk_prev = walk;
    prev_mode = m_mode;
    qe = m_q | press;
    if (m_mode == M_IDLE) begin
      if (press) m_mode = M_PEND;
    end else if (m_mode == M_PEND) begin
      if (walk) m_mode = M_SERV;
    end else if (m_mode == M_SERV) begin
      m_q = qe;
      if (fall) begin
        m_mode = M_LOCK;
        m_rem  = L;
      end
    end else begin
      if (m_rem == 1) begin
        m_mode = qe ? M_PEND : M_IDLE;
        m_q    = 0;
      end else begin
        m_rem = m_rem - 1;
        m_q   = qe;
      end
    end
    if (prev_mode != M_PEND && m_mode == M_PEND && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic step();
    bit r, w;
    r = bus.btn_raw;
    w = bus.walk;
    @(posedge clk);
    #1;
    model_edge(r, w);
    check("model_ped", bus.ped, (m_mode == M_PEND) ? 1 : 0);
    check("model_lockout", bus.lockout, (m_mode == M_LOCK) ? 1 : 0);
    check("model_btn_clean", bus.btn_clean, m_clean);
`ifdef PED_REQ_CNT_EN
    check("model_req_count", bus.req_count, m_cnt);
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int lock_seen;
    bit dropped;
    int raw_left, walk_left;

    for (int i = 0; i < 32; i++) begin
      tbl[i].raw     = (i < 20);
      tbl[i].walk    = (i >= 15 && i <= 18);
      tbl[i].e_ped   = (i >= 6 && i <= 14);
      tbl[i].e_lock  = (i >= 19 && i <= 26);
      tbl[i].e_clean = (i >= 5 && i <= 24);
    end

    // Reset with the button already held.
    rst_n = 1'b0;
    bus.btn_raw = 1'b1;
    bus.walk = 1'b0;
    model_reset();
    #22;
    check("reset_ped", bus.ped, 0);
    check("reset_btn_clean", bus.btn_clean, 0);
    check("reset_lockout", bus.lockout, 0);
`ifdef PED_REQ_CNT_EN
    check("reset_req_count", bus.req_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("release_ped_latency", bus.ped, (k >= 7) ? 1 : 0);
    end
    bus.btn_raw = 1'b0;
    bus.walk = 1'b1;
    steps(2);
    bus.walk = 1'b0;
    steps(20);

    // Bounce: 3 high, 2 low, 3 high.
    begin
      bit bp [20];
      for (int i = 0; i < 20; i++) bp[i] = (i < 3) || (i >= 5 && i < 8);
      for (int i = 0; i < 20; i++) begin
        bus.btn_raw = bp[i];
        step();
        check("bounce_btn_clean", bus.btn_clean, 0);
        check("bounce_ped", bus.ped, 0);
      end
    end

    // Clean 20-cycle press, serviced, lockout with no queued press.
    steps(10);
    for (int i = 0; i < 32; i++) begin
      bus.btn_raw = tbl[i].raw;
      bus.walk = tbl[i].walk;
      step();
      check("tbl_ped", bus.ped, tbl[i].e_ped);
      check("tbl_lockout", bus.lockout, tbl[i].e_lock);
      check("tbl_btn_clean", bus.btn_clean, tbl[i].e_clean);
    end

    // Press during lockout is queued and re-issued at lockout exit.
    bus.btn_raw = 1'b1;
    steps(10);
    check("queue_first_ped", bus.ped, 1);
    bus.btn_raw = 1'b0;
    steps(10);
    bus.walk = 1'b1;
    steps(3);
    bus.walk = 1'b0;
    bus.btn_raw = 1'b1;
    lock_seen = 0;
    dropped = 1'b0;
    for (int i = 0; i < 20 && !dropped; i++) begin
      step();
      if (bus.lockout) lock_seen++;
      else if (lock_seen > 0) dropped = 1'b1;
    end
    check("queue_lockout_exit_seen", dropped, 1);
    check("queue_lockout_len", lock_seen, L);
    check("queue_ped_after_lockout", bus.ped, 1);
    bus.btn_raw = 1'b0;
    bus.walk = 1'b1;
    steps(2);
    bus.walk = 1'b0;
    steps(20);
    check("noqueue_idle_ped", bus.ped, 0);
    check("noqueue_idle_lockout", bus.lockout, 0);

    // Walk while idle is ignored.
    bus.walk = 1'b1;
    steps(4);
    bus.walk = 1'b0;
    steps(4);
    check("idle_walk_ped", bus.ped, 0);
    check("idle_walk_lockout", bus.lockout, 0);

    // Asynchronous reset mid-PENDING.
    bus.btn_raw = 1'b1;
    steps(9);
    check("pre_arst_ped", bus.ped, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.btn_raw = 1'b0;
    #1;
    check("arst_ped_immediate", bus.ped, 0);
    model_reset();
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check("post_arst_ped", bus.ped, 0);
    end

`ifdef PED_REQ_CNT_EN
    for (int k = 1; k <= 5; k++) begin
      bus.btn_raw = 1'b1;
      steps(10);
      bus.btn_raw = 1'b0;
      bus.walk = 1'b1;
      steps(2);
      bus.walk = 1'b0;
      steps(20);
      check("req_count_sat", bus.req_count, (k < CMAX) ? k : CMAX);
    end
`endif

    // Randomized held-level stimulus against the model.
    raw_left = 0;
    walk_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (raw_left == 0) begin
        bus.btn_raw = 1'($urandom_range(0, 1));
        raw_left = $urandom_range(1, 10);
      end
      if (walk_left == 0) begin
        bus.walk = ($urandom_range(0, 3) == 0);
        walk_left = $urandom_range(1, 8);
      end
      raw_left--;
      walk_left--;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
